// File: rtl/reg_file_sb.sv
// Register file with one write port, two combinational read ports and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_WRITE_BYPASS_EN.
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_wr_ok;
  logic             w_set_ok;
  logic             w_zero1;
  logic             w_zero2;

  assign w_wr_ok  = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));
  assign w_zero1  = (ZERO_REG != 0) && (rd_addr1 == '0);
  assign w_zero2  = (ZERO_REG != 0) && (rd_addr2 == '0);

  // Set decode has priority so a new producer issued as the old one retires stays tracked.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign w_set[gi]       = w_set_ok && (busy_addr == ADDR_W'(gi));
    assign w_clr[gi]       = wr_en && (wr_addr == ADDR_W'(gi));
    assign w_busy_next[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_mem[wr_addr] <= wr_data;
      r_busy <= w_busy_next;
    end
  end

  assign busy_vec = r_busy;

`ifdef RF_WRITE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = w_wr_ok && !rst && (wr_addr == rd_addr1);
  assign w_byp2 = w_wr_ok && !rst && (wr_addr == rd_addr2);

  always_comb begin
    rd_data1 = w_zero1 ? '0 : (w_byp1 ? wr_data : r_mem[rd_addr1]);
    rd_data2 = w_zero2 ? '0 : (w_byp2 ? wr_data : r_mem[rd_addr2]);
  end

  // A retiring producer hides the busy bit unless a new producer targets the same register.
  assign busy1 = r_busy[rd_addr1] & ~(w_byp1 & ~(busy_set && (busy_addr == rd_addr1)));
  assign busy2 = r_busy[rd_addr2] & ~(w_byp2 & ~(busy_set && (busy_addr == rd_addr2)));
`else
  always_comb begin
    rd_data1 = w_zero1 ? '0 : r_mem[rd_addr1];
    rd_data2 = w_zero2 ? '0 : r_mem[rd_addr2];
  end

  assign busy1 = r_busy[rd_addr1];
  assign busy2 = r_busy[rd_addr2];
`endif

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file: one write port, two read ports, WIDTH-bit words, DEPTH entries.
- Carries a per-register busy (scoreboard) bit so the decode stage can detect RAW hazards on in-flight producers.
- Replaces hand-built bit-cell/tri-state arrays with a single synchronous-write, combinational-read storage block.
- Sits between decode (reads, busy_set) and writeback (writes).

Parameters:
- WIDTH, 16, data word width in bits
- DEPTH, 16, number of registers; power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is ordinary

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe, writeback stage
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  WIDTH  read port 1 data
- rd_data2  output  WIDTH  read port 2 data
- busy_set  input  1  mark busy_addr as having an in-flight producer
- busy_addr  input  ADDR_W  register to mark busy
- busy1  output  1  busy bit of rd_addr1
- busy2  output  1  busy bit of rd_addr2
- busy_vec  output  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
- Reset:
  - rst=1 at a rising edge clears all DEPTH registers to 0 and all busy bits to 0.
  - rst overrides wr_en and busy_set in the same cycle.
  - Asserting rst mid-stream discards pending busy state; there is no partial reset.
- Write:
  - At a rising edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data.
  - The new value is visible on the read ports from the next cycle (without WRITE_BYPASS_EN).
- Read:
  - Purely combinational: rd_dataN = mem[rd_addrN], zero added latency.
  - rd_addr1 == rd_addr2 is legal; both ports return the same value.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - busy_set to address 0 is dropped; busy_vec[0] is always 0.
- Scoreboard, per register i, at each rising edge with rst=0:
  - If busy_set && busy_addr==i: busy[i] <= 1.
  - Else if wr_en && wr_addr==i: busy[i] <= 0.
  - Else busy[i] holds.
  - Set wins over clear on the same address in the same cycle: a new producer is issued as the old one retires.
  - Set and clear on different addresses in the same cycle both take effect.
  - busy_set on an already-busy register keeps it busy; it is a single bit, not a counter.
  - A write to a non-busy register is legal and leaves busy at 0.
- Busy outputs: busy1/busy2 = busy_vec[rd_addr1]/busy_vec[rd_addr2], combinational, reflecting registered state only.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Outputs after reset: rd_data1 = rd_data2 = 0, busy1 = busy2 = 0, busy_vec = 0.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined:
  - When wr_en=1 and wr_addr==rd_addrN (and the address is not the hardwired zero register), rd_dataN = wr_data in the same cycle.
  - busyN reads 0 in that case, since the producer retires this cycle, unless busy_set targets the same address in the same cycle.
  - rst=1 suppresses the bypass.
- Undefined:
  - Reads return stored contents only; same-cycle write data appears the next cycle.
  - busyN reflects registered state only.

Test Plan:
- Reset: write 0xBEEF to r5, assert rst one cycle -> rd_data1 (rd_addr1=5) = 0x0000, busy_vec = 0 next cycle.
- Write/read: write 0x1234 to r3, then rd_addr1=3, rd_addr2=3 -> both ports 0x1234 the cycle after the write. Without the macro, the same-cycle read shows the old value 0x0000. With RF_WRITE_BYPASS_EN, the same-cycle read shows 0x1234.
- Zero register (ZERO_REG=1): write 0xFFFF to r0, busy_set r0 -> rd_data1 = 0x0000, busy_vec[0] = 0.
- Scoreboard: busy_set r7 -> busy1 (rd_addr1=7) = 1 next cycle; write r7 = 0x00AA -> busy1 = 0 next cycle, rd_data1 = 0x00AA.
- Simultaneous events: busy r4; then in one cycle wr_en r4 = 0x0011 and busy_set r4 -> busy_vec[4] stays 1, mem[4] = 0x0011. Separately, busy_set r2 with write r9 (r9 busy) -> busy_vec[2] = 1, busy_vec[9] = 0.
- Parameter sweep WIDTH=32, DEPTH=8, ZERO_REG=0: write 0xDEADBEEF to r0 and r7 -> both read back 0xDEADBEEF; busy_set r0 -> busy_vec = 8'h01.
